nanov_digit_alu: RTL and testbench
==================================

Name: nanov_digit_alu

Overview:
Digit-serial ALU for the nanoV core, a parametrised successor to the 1-bit serial ALU.
- Processes an XLEN-bit operation DIGIT_W bits per cycle, LSB digit first.
- Holds carry, opcode and a digit counter internally, so the core streams operand digits and needs no external carry feedback.
- Sits between the register-file shifters and the writeback path.

Parameters:
XLEN, 32, operand width in bits.
DIGIT_W, 4, bits per cycle; power of two, 1..XLEN, must divide XLEN. NDIG = XLEN/DIGIT_W.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  begin an operation; digit 0 is on a/b in the same cycle.
op  in  4  opcode, sampled only on an accepted start: 0000 ADD, 1000 SUB, 0010 SLT, 0011 SLTU, 0111 AND, 0110 OR, 0100 XOR.
a  in  DIGIT_W  operand A digit.
b  in  DIGIT_W  operand B digit.
busy  out  1  high while digits 1..NDIG-1 are being consumed.
d_valid  out  1  d holds a result digit this cycle.
d  out  DIGIT_W  result digit, registered.
digit_idx  out  $clog2(NDIG) (min 1)  index of the digit currently on d.
done  out  1  one-cycle pulse coincident with the last d_valid.
cmp_out  out  1  SLT/SLTU result (1 iff A<B); valid from done, held until the next done.
cy_out  out  1  final carry-out of the adder; valid from done, held until the next done.

Behaviour:
- Reset (async, rst=1): state IDLE, counter 0, carry 0, op_r 0. All outputs 0: busy, d_valid, d, digit_idx, done, cmp_out, cy_out.
- States: IDLE and RUN.
  - IDLE with start=1: latch op into op_r; consume digit 0 using carry-in cin = op[1]|op[3]; counter<=1. Go to RUN if NDIG>1, else stay in IDLE.
  - RUN: consume digit counter using the stored carry; counter++. When counter==NDIG-1, go to IDLE.
  - start is ignored while in RUN.
- busy = (state==RUN), registered.
- Digits must arrive on consecutive cycles; there is no stall input.
- Gapless back-to-back: start is accepted in the first IDLE cycle after the last digit is consumed.
- Adder per digit: b' = (op_r[1]|op_r[3]) ? ~b : b. {c, s} = a + b' + cin, width DIGIT_W+1. Carry register <= c.
- Result select, by op_r[2:0]:
  - 000 → s.
  - 111 → a&b.
  - 110 → a|b.
  - 100 → a^b.
  - 010/011 → 0.
  - Any other code → 0, with cmp_out=0.
- Latency: d/d_valid/digit_idx are registered, appearing 1 cycle after the digit is consumed. Digit k of the result appears at cycle k+1 after start.
- On the final digit (idx NDIG-1), registered with done:
  - cy_out <= c.
  - SLT: cmp_out <= a[MSB] ^ b'[MSB] ^ c.
  - SLTU: cmp_out <= ~c.
  - Other ops: cmp_out <= 0.
- Between operations, d_valid=0 and d=0; cmp_out and cy_out hold their last values.
- Reset mid-operation: abort immediately. No done is produced. The next start begins cleanly.
- NDIG==1: single-cycle op; busy never asserts; done follows start by 1 cycle.

Optional Feature:
NANOV_ALU_EQ_EN: adds output eq_out (1 bit).
- With the macro: during the operation, an internal flag accumulates AND over digits of (a==b). eq_out is registered with done, held until the next done, and reset to 0. eq_out is valid for every opcode, enabling BEQ/BNE without a separate XOR pass.
- Without the macro: eq_out and its flag logic do not exist. All other behaviour is identical.

Test Plan:
All scenarios use XLEN=32, DIGIT_W=4.
1. ADD 0xFFFFFFFF + 0x00000001 → 8 d_valid digits all 0x0, digit_idx 0..7, done on the 8th, cy_out=1.
2. SUB 5 − 7 → result digits assemble to 0xFFFFFFFE; cy_out=0.
3. SLT 0x80000000 vs 0x00000001 → cmp_out=1, all d=0. Then SLTU with the same operands → cmp_out=0.
4. AND/OR/XOR 0xF0F0A5A5 with 0x0FF05A5A → 0x00F00000, 0xFFF0FFFF, 0xFF00FFFF. Issue the three ops back-to-back with start on the cycle after each last digit: no gap in d_valid, and start pulses during busy are ignored.
5. Reset asserted at digit 3 of an ADD → all outputs 0 asynchronously, no done. A following ADD 2+3 → 0x00000005.
6. Repeat scenarios 1 and 3 with DIGIT_W=1 (32 digits) and DIGIT_W=32 (busy never high, done 1 cycle after start). With NANOV_ALU_EQ_EN, 0x1234 vs 0x1234 → eq_out=1, and 0x1234 vs 0x1235 → eq_out=0.

Source files
------------

// File: rtl/nanov_digit_alu_if.sv
// Operand/result bundle between the nanoV core and the digit-serial ALU.
// eq_out exists only when NANOV_ALU_EQ_EN is defined.
interface nanov_digit_alu_if #(
    parameter int XLEN    = 32,
    parameter int DIGIT_W = 4
);
    localparam int NDIG  = XLEN / DIGIT_W;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic               start;
    logic [3:0]         op;
    logic [DIGIT_W-1:0] a;
    logic [DIGIT_W-1:0] b;
    logic               busy;
    logic               d_valid;
    logic [DIGIT_W-1:0] d;
    logic [IDX_W-1:0]   digit_idx;
    logic               done;
    logic               cmp_out;
    logic               cy_out;
`ifdef NANOV_ALU_EQ_EN
    logic               eq_out;
`endif

    modport master (
        output start, op, a, b,
`ifdef NANOV_ALU_EQ_EN
        input  eq_out,
`endif
        input  busy, d_valid, d, digit_idx, done, cmp_out, cy_out
    );

    modport slave (
        input  start, op, a, b,
`ifdef NANOV_ALU_EQ_EN
        output eq_out,
`endif
        output busy, d_valid, d, digit_idx, done, cmp_out, cy_out
    );
endinterface

// File: rtl/nanov_digit_alu.sv
// Digit-serial ALU: XLEN-bit op, DIGIT_W bits per cycle, LSB digit first.
// Optional equality output enabled by NANOV_ALU_EQ_EN.
module nanov_digit_alu #(
    parameter int XLEN    = 32,
    parameter int DIGIT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    nanov_digit_alu_if.slave    bus
);
    localparam int NDIG  = XLEN / DIGIT_W;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    // state | meaning
    // IDLE  | waiting for start; digit 0 is consumed in the start cycle
    // RUN   | consuming digits 1..NDIG-1 on consecutive cycles
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_carry, w_carry_nxt;
    logic [3:0]         r_op, w_op_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_d_valid, w_d_valid_nxt;
    logic [DIGIT_W-1:0] r_d, w_d_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic               r_done, w_done_nxt;
    logic               r_cmp, w_cmp_nxt;
    logic               r_cy, w_cy_nxt;

    logic               w_accept, w_consume, w_inv, w_cin, w_last;
    logic [3:0]         w_op;
    logic [DIGIT_W-1:0] w_b, w_res;
    logic [DIGIT_W:0]   w_sum;
    logic [IDX_W-1:0]   w_idx;

`ifdef NANOV_ALU_EQ_EN
    logic r_eq_acc, w_eq_acc_nxt;
    logic r_eq, w_eq_nxt;
    logic w_dig_eq;
`endif

    always_comb begin
        w_accept  = (r_state == S_IDLE) && bus.start;
        w_consume = w_accept || (r_state == S_RUN);
        w_op      = w_accept ? bus.op : r_op;
        w_inv     = w_op[1] | w_op[3];
        w_cin     = w_accept ? w_inv : r_carry;
        w_b       = w_inv ? ~bus.b : bus.b;
        w_sum     = {1'b0, bus.a} + {1'b0, w_b} + {{DIGIT_W{1'b0}}, w_cin};
        w_idx     = w_accept ? '0 : r_cnt;
        w_last    = w_consume && (w_idx == IDX_W'(NDIG - 1));

        case (w_op[2:0])
            3'b000:  w_res = w_sum[DIGIT_W-1:0];
            3'b111:  w_res = bus.a & bus.b;
            3'b110:  w_res = bus.a | bus.b;
            3'b100:  w_res = bus.a ^ bus.b;
            default: w_res = '0;
        endcase

        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_carry_nxt = r_carry;
        w_op_nxt    = r_op;
        w_cmp_nxt   = r_cmp;
        w_cy_nxt    = r_cy;

        if (w_accept) begin
            w_op_nxt  = bus.op;
            w_cnt_nxt = IDX_W'(1);
            if (NDIG > 1)
                w_state_nxt = S_RUN;
        end else if (r_state == S_RUN) begin
            if (w_last) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt + IDX_W'(1);
            end
        end

        if (w_consume)
            w_carry_nxt = w_sum[DIGIT_W];

        // Signed less-than is N^V, which collapses to a^b'^carry_out at the MSB.
        if (w_last) begin
            w_cy_nxt = w_sum[DIGIT_W];
            case (w_op[2:0])
                3'b010:  w_cmp_nxt = bus.a[DIGIT_W-1] ^ w_b[DIGIT_W-1] ^ w_sum[DIGIT_W];
                3'b011:  w_cmp_nxt = ~w_sum[DIGIT_W];
                default: w_cmp_nxt = 1'b0;
            endcase
        end

        w_busy_nxt    = (w_state_nxt == S_RUN);
        w_d_valid_nxt = w_consume;
        w_d_nxt       = w_consume ? w_res : '0;
        w_idx_nxt     = w_consume ? w_idx : '0;
        w_done_nxt    = w_last;

`ifdef NANOV_ALU_EQ_EN
        w_dig_eq     = (bus.a == bus.b);
        w_eq_acc_nxt = r_eq_acc;
        w_eq_nxt     = r_eq;
        if (w_accept)
            w_eq_acc_nxt = w_dig_eq;
        else if (r_state == S_RUN)
            w_eq_acc_nxt = r_eq_acc & w_dig_eq;
        if (w_last)
            w_eq_nxt = (w_accept ? 1'b1 : r_eq_acc) & w_dig_eq;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_carry   <= 1'b0;
            r_op      <= '0;
            r_busy    <= 1'b0;
            r_d_valid <= 1'b0;
            r_d       <= '0;
            r_idx     <= '0;
            r_done    <= 1'b0;
            r_cmp     <= 1'b0;
            r_cy      <= 1'b0;
`ifdef NANOV_ALU_EQ_EN
            r_eq_acc  <= 1'b0;
            r_eq      <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_carry   <= w_carry_nxt;
            r_op      <= w_op_nxt;
            r_busy    <= w_busy_nxt;
            r_d_valid <= w_d_valid_nxt;
            r_d       <= w_d_nxt;
            r_idx     <= w_idx_nxt;
            r_done    <= w_done_nxt;
            r_cmp     <= w_cmp_nxt;
            r_cy      <= w_cy_nxt;
`ifdef NANOV_ALU_EQ_EN
            r_eq_acc  <= w_eq_acc_nxt;
            r_eq      <= w_eq_nxt;
`endif
        end
    end

    assign bus.busy      = r_busy;
    assign bus.d_valid   = r_d_valid;
    assign bus.d         = r_d;
    assign bus.digit_idx = r_idx;
    assign bus.done      = r_done;
    assign bus.cmp_out   = r_cmp;
    assign bus.cy_out    = r_cy;
`ifdef NANOV_ALU_EQ_EN
    assign bus.eq_out    = r_eq;
`endif
endmodule

// File: tb/tb_nanov_digit_alu.sv
// Bench for nanov_digit_alu: directed and random ops against a word-level model.
// Equality checks are compiled in when NANOV_ALU_EQ_EN is defined.
module tb_nanov_digit_alu;
    parameter int XLEN    = 32;
    parameter int DIGIT_W = 4;
    localparam int NDIG  = XLEN / DIGIT_W;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nanov_digit_alu_if #(.XLEN(XLEN), .DIGIT_W(DIGIT_W)) u_if ();

    nanov_digit_alu #(.XLEN(XLEN), .DIGIT_W(DIGIT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]      q_op[$];
    logic [XLEN-1:0] q_a[$];
    logic [XLEN-1:0] q_b[$];
    logic            exp_cmp = 1'b0;
    logic            exp_cy  = 1'b0;
    logic            exp_eq  = 1'b0;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_result(input logic [3:0] op, input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        case (op[2:0])
            3'b000:  return op[3] ? a - b : a + b;
            3'b111:  return a & b;
            3'b110:  return a | b;
            3'b100:  return a ^ b;
            default: return '0;
        endcase
    endfunction

    function automatic logic ref_cy(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [XLEN:0] t;
        if (op[1] | op[3]) t = {1'b0, a} + {1'b0, ~b} + 1;
        else               t = {1'b0, a} + {1'b0, b};
        return t[XLEN];
    endfunction

    function automatic logic ref_cmp(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        if (op == OP_SLT)  return $signed(a) < $signed(b);
        if (op == OP_SLTU) return a < b;
        return 1'b0;
    endfunction

    task automatic check_idle();
        chk("idle_d_valid", u_if.d_valid, 0);
        chk("idle_d", u_if.d, 0);
        chk("idle_done", u_if.done, 0);
        chk("idle_busy", u_if.busy, 0);
        chk("idle_cmp_hold", u_if.cmp_out, exp_cmp);
        chk("idle_cy_hold", u_if.cy_out, exp_cy);
    endtask

    // Streams every queued op back-to-back and checks each result cycle.
    task automatic run_seq();
        int n, total, p, k;
        logic [XLEN-1:0] wa, wb, wr, acc;
        n     = q_op.size();
        total = n * NDIG;
        acc   = '0;
        for (int t = 0; t <= total; t++) begin
            @(negedge clk);
            if (t > 0) begin
                p  = (t - 1) / NDIG;
                k  = (t - 1) % NDIG;
                wr = ref_result(q_op[p], q_a[p], q_b[p]);
                chk("d_valid", u_if.d_valid, 1);
                chk("digit_idx", u_if.digit_idx, k);
                chk("d", u_if.d, wr[k*DIGIT_W +: DIGIT_W]);
                chk("busy", u_if.busy, (k < NDIG - 1));
                chk("done", u_if.done, (k == NDIG - 1));
                acc[k*DIGIT_W +: DIGIT_W] = u_if.d;
                if (k == NDIG - 1) begin
                    exp_cmp = ref_cmp(q_op[p], q_a[p], q_b[p]);
                    exp_cy  = ref_cy(q_op[p], q_a[p], q_b[p]);
                    exp_eq  = (q_a[p] == q_b[p]);
                    chk("result_word", acc, wr);
`ifdef NANOV_ALU_EQ_EN
                    chk("eq_out", u_if.eq_out, exp_eq);
`endif
                end
                chk("cmp_out", u_if.cmp_out, exp_cmp);
                chk("cy_out", u_if.cy_out, exp_cy);
            end
            if (t < total) begin
                p  = t / NDIG;
                k  = t % NDIG;
                wa = q_a[p];
                wb = q_b[p];
                u_if.start = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                u_if.op    = (k == 0) ? q_op[p] : 4'($urandom);
                u_if.a     = wa[k*DIGIT_W +: DIGIT_W];
                u_if.b     = wb[k*DIGIT_W +: DIGIT_W];
            end else begin
                u_if.start = 1'b0;
                u_if.op    = 4'($urandom);
                u_if.a     = DIGIT_W'($urandom);
                u_if.b     = DIGIT_W'($urandom);
            end
        end
        @(negedge clk);
        check_idle();
        q_op.delete();
        q_a.delete();
        q_b.delete();
    endtask

    task automatic push(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        q_op.push_back(op);
        q_a.push_back(a);
        q_b.push_back(b);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, u_if.busy, 0);
        chk({tag, "_d_valid"}, u_if.d_valid, 0);
        chk({tag, "_d"}, u_if.d, 0);
        chk({tag, "_digit_idx"}, u_if.digit_idx, 0);
        chk({tag, "_done"}, u_if.done, 0);
        chk({tag, "_cmp"}, u_if.cmp_out, 0);
        chk({tag, "_cy"}, u_if.cy_out, 0);
`ifdef NANOV_ALU_EQ_EN
        chk({tag, "_eq"}, u_if.eq_out, 0);
`endif
    endtask

    logic [3:0] rand_ops [9] = '{OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_AND, OP_OR, OP_XOR, 4'b0001, 4'b1001};

    initial begin
        logic [XLEN-1:0] ra, rb;
        rst        = 1'b1;
        u_if.start = 1'b0;
        u_if.op    = '0;
        u_if.a     = '0;
        u_if.b     = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        push(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
        run_seq();
        push(OP_SUB, 32'd5, 32'd7);
        run_seq();
        push(OP_SLT, 32'h8000_0000, 32'h0000_0001);
        run_seq();
        push(OP_SLTU, 32'h8000_0000, 32'h0000_0001);
        run_seq();

        push(OP_AND, 32'hF0F0_A5A5, 32'h0FF0_5A5A);
        push(OP_OR,  32'hF0F0_A5A5, 32'h0FF0_5A5A);
        push(OP_XOR, 32'hF0F0_A5A5, 32'h0FF0_5A5A);
        run_seq();

        // Leave cmp_out/cy_out at 1 so the abort visibly clears them.
        push(OP_SLT, 32'h8000_0000, 32'h0000_0001);
        run_seq();
        u_if.start = 1'b1;
        u_if.op    = OP_ADD;
        for (int k = 0; k < 4 && k < NDIG; k++) begin
            u_if.a = DIGIT_W'($urandom);
            u_if.b = DIGIT_W'($urandom);
            @(negedge clk);
            u_if.start = 1'b0;
        end
        #2 rst = 1'b1;
        #1 check_all_zero("abort");
        @(negedge clk);
        check_all_zero("abort_hold");
        rst     = 1'b0;
        exp_cmp = 1'b0;
        exp_cy  = 1'b0;
        push(OP_ADD, 32'd2, 32'd3);
        run_seq();

        push(OP_ADD, 32'h0000_1234, 32'h0000_1234);
        push(OP_XOR, 32'h0000_1234, 32'h0000_1235);
        run_seq();

        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 5; i++) begin
                ra = $urandom;
                rb = ($urandom_range(0, 3) == 0) ? ra : XLEN'($urandom);
                push(rand_ops[$urandom_range(0, 8)], ra, rb);
            end
            run_seq();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
